load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the processor execute stage and `data_memory`, a 1024x32 block RAM with a 1-cycle registered read.
- Takes one load/store request per transaction over a valid/ready handshake and computes the byte address as base + offset.
- Drives the memory port, absorbing the RAM read latency.
- Implements byte and halfword accesses on word-wide memory: sign/zero extension for loads, read-modify-write for stores.

Parameters:
ADDR_W, 10, word-address width driven to data_memory; byte address bits [ADDR_W+1:2] form the word index.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE, not in reset)
- req_is_store  input  1  1=store, 0=load
- req_size  input  2  00=byte, 01=half, 10=word, 11=illegal
- req_signed  input  1  loads: 1=sign-extend, 0=zero-extend
- req_base  input  32  base register value
- req_offset  input  32  immediate offset
- req_wdata  input  32  store data (low byte/half used for subword)
- resp_valid  output  1  one-cycle pulse: transaction complete
- resp_data  output  32  load result (0 for stores/errors)
- resp_err  output  1  valid with resp_valid: misaligned or illegal size
- busy  output  1  state != IDLE (pipeline stall)
- mem_addr  output  ADDR_W  word address to data_memory
- mem_read  output  1  RAM enable (ena)
- mem_write  output  1  RAM write enable (wea)
- mem_wdata  output  32  RAM write data
- mem_rdata  input  32  RAM read data, valid the cycle after an enabled edge

Behaviour:
- Address: ea = req_base + req_offset (32-bit, wraps, no overflow flag); word = ea[ADDR_W+1:2]; lane = ea[1:0]. Upper address bits are ignored (aliasing).
- Little-endian lanes: byte lane n = bits [8n+7:8n]; half lane ea[1] selects [15:0] or [31:16].
- Error conditions: size 11, half with ea[0]=1, word with ea[1:0]!=0. On error no mem_read/mem_write is issued.
- Accept: request accepted when req_valid && req_ready at a rising edge. All request fields are latched then; inputs are don't-care afterwards.
- FSM states:
  - IDLE: on accept go to ERR if error; else RD if load; WR if word store; RMW_RD if subword store.
  - RD: mem_read=1. Next: RD_WAIT.
  - RD_WAIT: mem_rdata valid. At the edge, extract/extend into resp_data, pulse resp_valid, go to IDLE.
  - RMW_RD: mem_read=1. Next: RMW_MERGE.
  - RMW_MERGE: at the edge, merge the store byte/half into mem_rdata at the lane, into the wdata register. Next: WR.
  - WR: mem_read=1 AND mem_write=1 (RAM enable gates writes), mem_wdata=merged or full word. At the edge, pulse resp_valid (resp_data=0), go to IDLE.
  - ERR: at the next edge, pulse resp_valid with resp_err=1, resp_data=0, go to IDLE.
- Latency, counting cycles after the accept edge until resp_valid is high: load 2; word store 1 (WR); subword store 3; error 1 (ERR).
- mem_addr is held stable from RD/RMW_RD through WR. mem_read/mem_write are 0 in IDLE, ERR and RD_WAIT.
- resp_valid is high exactly one cycle, coincident with return to IDLE, so req_ready=1 in that same cycle: back-to-back requests are allowed with no bubble.
- resp_data holds its last load value until the next response; it is cleared for store/error responses.
- Reset (any state, including mid-RMW): next edge forces IDLE. All outputs are 0, including req_ready during rst; req_ready=1 the first cycle after rst deasserts. An aborted RMW performs no write.
- mem_rdata is ignored outside RD_WAIT/RMW_MERGE.

Test Plan:
1. Word store then load: store base=0x100, off=0x4, data=0xDEADBEEF. Expect mem_write with mem_addr=0x41, and resp_valid 1 cycle after accept. Then load word at the same ea: resp_data=0xDEADBEEF, resp_valid 2 cycles after accept.
2. Byte store RMW: word 0x41 = 0x11223344. Store byte 0xAB at ea=0x106. Expect mem_wdata=0x11AB3344, then resp_valid 3 cycles after accept.
3. Sign extension on word 0x11AB3344:
   - signed byte load ea=0x106 -> 0xFFFFFFAB
   - unsigned -> 0x000000AB
   - signed half ea=0x104 -> 0x00003344
   - signed half ea=0x106 -> 0x000011AB
4. Misalignment: word load ea=0x102 and half store ea=0x101, each -> resp_err=1, resp_data=0, resp_valid 1 cycle after accept, mem_read/mem_write never asserted.
5. Back-to-back: req_valid held high with 4 alternating load/store requests. Each is accepted in the resp_valid cycle of the previous one; no gaps; memory contents correct.
6. Reset in RMW_MERGE during byte store to word 0x41: no write occurs, word unchanged, all outputs 0, req_ready=1 one cycle after rst falls.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a 1-cycle-latency word RAM.
// Handles byte/half/word accesses, sign/zero extension and read-modify-write stores.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_base,
  input  logic [31:0]       req_offset,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    RMW_RD,
    RMW_MERGE,
    WR,
    ERR
  } state_t;

  state_t state, state_nx;

  logic [31:0]       ea;
  logic              ea_unused;
  logic              req_err;
  logic              accept;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [31:0]       wdata_q;

  logic              resp_valid_q;
  logic              resp_err_q;
  logic [31:0]       resp_data_q;

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  logic              mem_read_c;
  logic              mem_write_c;

  assign ea = req_base + req_offset;

  // Address bits above the word index alias onto the same RAM word.
  assign ea_unused = ^ea[31:ADDR_W+2];

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = ea[0];
      2'b10:   req_err = |ea[1:0];
      default: req_err = 1'b1;
    endcase
  end

  assign accept = req_valid && req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                  state_nx = ERR;
          else if (!req_is_store)       state_nx = RD;
          else if (req_size == 2'b10)   state_nx = WR;
          else                          state_nx = RMW_RD;
        end
      end
      RD:        state_nx = RD_WAIT;
      RD_WAIT:   state_nx = IDLE;
      RMW_RD:    state_nx = RMW_MERGE;
      RMW_MERGE: state_nx = WR;
      WR:        state_nx = IDLE;
      ERR:       state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    case (state)
      RD, RMW_RD: mem_read_c = 1'b1;
      WR: begin
        mem_read_c  = 1'b1;
        mem_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
  assign half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_val = mem_rdata;
    case (size_q)
      2'b00:   load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
    else                 merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      lane_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      if (accept) begin
        addr_q   <= ea[ADDR_W+1:2];
        lane_q   <= ea[1:0];
        size_q   <= req_size;
        signed_q <= req_signed;
        wdata_q  <= req_wdata;
      end
      case (state)
        RD_WAIT: begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= load_val;
        end
        RMW_MERGE: wdata_q <= merged;
        WR: begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= '0;
        end
        ERR: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_data_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Everything reads as zero while reset is held, whatever state is being left.
  assign req_ready  = (state == IDLE) && !rst;
  assign busy       = (state != IDLE) && !rst;
  assign mem_read   = mem_read_c && !rst;
  assign mem_write  = mem_write_c && !rst;
  assign mem_addr   = rst ? '0 : addr_q;
  assign mem_wdata  = rst ? '0 : wdata_q;
  assign resp_valid = resp_valid_q && !rst;
  assign resp_err   = resp_err_q && !rst;
  assign resp_data  = rst ? '0 : resp_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 1024x32 registered-read RAM.
module tb_load_store_unit;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_is_store = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_signed = 1'b0;
  logic [31:0]       req_base = '0;
  logic [31:0]       req_offset = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_read) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
    if (mem_read && mem_write) wr_count <= wr_count + 1;
  end

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_signed(req_signed), .req_base(req_base),
    .req_offset(req_offset), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic set_req(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd);
    req_is_store = st;
    req_size     = sz;
    req_signed   = sg;
    req_base     = base;
    req_offset   = off;
    req_wdata    = wd;
  endtask

  // Issues one request and records latency (edges after accept), response and memory activity.
  task automatic run_req(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd,
                         output int lat, output logic [31:0] data, output logic err,
                         output logic sawr, output logic saww,
                         output logic [31:0] wword, output logic [ADDR_W-1:0] waddr);
    int t;
    lat = -1; data = '0; err = 1'b0; sawr = 1'b0; saww = 1'b0; wword = '0; waddr = '0;
    @(negedge clk);
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    set_req(st, sz, sg, base, off, wd);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read) sawr = 1'b1;
      if (mem_write) begin
        saww  = 1'b1;
        wword = mem_wdata;
        waddr = mem_addr;
      end
      if (resp_valid) begin
        lat  = c - 1;
        data = resp_data;
        err  = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_err, busy, mem_read, mem_write} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 000000",
               {req_ready, resp_valid, resp_err, busy, mem_read, mem_write});
    end
    n_checks++;
    if (resp_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h exp 00000000", resp_data);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release ready=%b busy=%b exp ready=1 busy=0", req_ready, busy);
    end
  endtask

  task automatic test_word_store_load();
    int lat; logic [31:0] d, ww; logic e, sr, sw; logic [ADDR_W-1:0] wa;
    run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h4, 32'hDEADBEEF, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (!sw || wa !== 10'h041 || ww !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wstore_mem write=%b addr=%h data=%h exp write=1 addr=041 data=deadbeef", sw, wa, ww);
    end
    n_checks++;
    if (lat !== 1 || d !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL wstore_resp lat=%0d data=%h err=%b exp lat=1 data=0 err=0", lat, d, e);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h4, 32'h0, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (lat !== 2 || d !== 32'hDEADBEEF || sw !== 1'b0) begin
      n_fail++;
      $display("FAIL wload lat=%0d data=%h write=%b exp lat=2 data=deadbeef write=0", lat, d, sw);
    end
  endtask

  task automatic test_byte_rmw();
    int lat; logic [31:0] d, ww; logic e, sr, sw; logic [ADDR_W-1:0] wa;
    run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h4, 32'h11223344, lat, d, e, sr, sw, ww, wa);
    run_req(1'b1, 2'b00, 1'b0, 32'h100, 32'h6, 32'h123456AB, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (ww !== 32'h11AB3344 || wa !== 10'h041) begin
      n_fail++;
      $display("FAIL rmw_wdata got addr=%h data=%h exp addr=041 data=11ab3344", wa, ww);
    end
    n_checks++;
    if (lat !== 3 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL rmw_latency lat=%0d data=%h exp lat=3 data=0", lat, d);
    end
  endtask

  task automatic test_sign_ext();
    int lat; logic [31:0] d, ww; logic e, sr, sw; logic [ADDR_W-1:0] wa;
    run_req(1'b0, 2'b00, 1'b1, 32'h100, 32'h6, 32'h0, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (d !== 32'hFFFFFFAB) begin
      n_fail++;
      $display("FAIL lb_signed got %h exp ffffffab", d);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'hFFFFFFAB) begin
      n_fail++;
      $display("FAIL resp_hold valid=%b data=%h exp valid=0 data=ffffffab", resp_valid, resp_data);
    end
    run_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h6, 32'h0, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (d !== 32'h000000AB) begin
      n_fail++;
      $display("FAIL lbu got %h exp 000000ab", d);
    end
    run_req(1'b0, 2'b01, 1'b1, 32'h100, 32'h4, 32'h0, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (d !== 32'h00003344) begin
      n_fail++;
      $display("FAIL lh_low got %h exp 00003344", d);
    end
    run_req(1'b0, 2'b01, 1'b1, 32'h108, 32'hFFFFFFFE, 32'h0, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (d !== 32'h000011AB) begin
      n_fail++;
      $display("FAIL lh_high_wrap got %h exp 000011ab", d);
    end
    run_req(1'b0, 2'b00, 1'b1, 32'h100, 32'h5, 32'h0, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (d !== 32'h00000033) begin
      n_fail++;
      $display("FAIL lb_lane1 got %h exp 00000033", d);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h104, 32'h0, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (d !== 32'h11AB3344) begin
      n_fail++;
      $display("FAIL alias_load got %h exp 11ab3344", d);
    end
  endtask

  task automatic test_misalign();
    int lat; logic [31:0] d, ww; logic e, sr, sw; logic [ADDR_W-1:0] wa;
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h2, 32'h0, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (lat !== 1 || e !== 1'b1 || d !== 32'h0 || sr !== 1'b0 || sw !== 1'b0) begin
      n_fail++;
      $display("FAIL err_word lat=%0d err=%b data=%h rd=%b wr=%b exp 1 1 0 0 0", lat, e, d, sr, sw);
    end
    run_req(1'b1, 2'b01, 1'b0, 32'h100, 32'h1, 32'hFFFF, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (lat !== 1 || e !== 1'b1 || d !== 32'h0 || sr !== 1'b0 || sw !== 1'b0) begin
      n_fail++;
      $display("FAIL err_half lat=%0d err=%b data=%h rd=%b wr=%b exp 1 1 0 0 0", lat, e, d, sr, sw);
    end
    run_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h4, 32'h0, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (lat !== 1 || e !== 1'b1 || sr !== 1'b0) begin
      n_fail++;
      $display("FAIL err_size lat=%0d err=%b rd=%b exp 1 1 0", lat, e, sr);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h4, 32'h0, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (e !== 1'b0 || d !== 32'h11AB3344) begin
      n_fail++;
      $display("FAIL err_clear err=%b data=%h exp err=0 data=11ab3344", e, d);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int lat; logic [31:0] d, ww; logic e, sr, sw; logic [ADDR_W-1:0] wa;
    int wc0;
    @(negedge clk);
    set_req(1'b1, 2'b00, 1'b0, 32'h100, 32'h5, 32'h55);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wc0 = wr_count;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL rmw_merge_state busy=%b rd=%b exp busy=1 rd=0", busy, mem_read);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_err, busy, mem_read, mem_write} !== 6'b0 ||
        resp_data !== 32'h0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_outputs ctrl=%b data=%h addr=%h wdata=%h exp all zero",
               {req_ready, resp_valid, resp_err, busy, mem_read, mem_write},
               resp_data, mem_addr, mem_wdata);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_held ready=%b wr=%b exp 0 0", req_ready, mem_write);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready ready=%b busy=%b exp ready=1 busy=0", req_ready, busy);
    end
    n_checks++;
    if (wr_count !== wc0) begin
      n_fail++;
      $display("FAIL rst_no_write writes=%0d exp %0d", wr_count, wc0);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h4, 32'h0, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (d !== 32'h11AB3344) begin
      n_fail++;
      $display("FAIL rst_word_kept got %h exp 11ab3344", d);
    end
  endtask

  task automatic test_back_to_back();
    logic        st  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sz  [4] = '{2'b10, 2'b10, 2'b00, 2'b01};
    logic [31:0] off [4] = '{32'h0, 32'h0, 32'h1, 32'h0};
    logic [31:0] wd  [4] = '{32'hCAFEF00D, 32'h0, 32'h00000077, 32'h0};
    logic [31:0] exp [4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'h0000770D};
    int  nacc, nresp, lat;
    logic acc_now;
    logic [31:0] d, ww; logic e, sr, sw; logic [ADDR_W-1:0] wa;
    nacc = 0;
    nresp = 0;
    @(negedge clk);
    set_req(st[0], sz[0], 1'b0, 32'h200, off[0], wd[0]);
    req_valid = 1'b1;
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      if (resp_valid) begin
        n_checks++;
        if (resp_data !== exp[nresp]) begin
          n_fail++;
          $display("FAIL b2b_data[%0d] got %h exp %h", nresp, resp_data, exp[nresp]);
        end
        if (nresp < 3) begin
          n_checks++;
          if (req_ready !== 1'b1 || req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_nogap[%0d] ready=%b valid=%b exp 1 1", nresp, req_ready, req_valid);
          end
        end
        nresp++;
      end
      acc_now = req_ready && req_valid;
      if (acc_now) nacc++;
      @(posedge clk);
      #1;
      if (acc_now) begin
        if (nacc < 4) set_req(st[nacc], sz[nacc], 1'b0, 32'h200, off[nacc], wd[nacc]);
        else          req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_checks++;
    if (nresp !== 4) begin
      n_fail++;
      $display("FAIL b2b_timeout responses=%0d exp 4", nresp);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0, lat, d, e, sr, sw, ww, wa);
    n_checks++;
    if (d !== 32'hCAFE770D) begin
      n_fail++;
      $display("FAIL b2b_mem got %h exp cafe770d", d);
    end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_sign_ext();
    test_misalign();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
